ball_track_ctrl: RTL and testbench

Frame-level controller that sequences the ball detection datapath. It arms the detector on a clean frame boundary and qualifies each per-frame ball result against a pixel-count threshold and a spatial-continuity rule. Confirmed ball positions go to the downstream paddle/game logic over a valid/ready handshake. It sits between the VGA timing and detector outputs and the game controller, and owns the detector's ENABLE.

---
 rtl/ball_track_ctrl.sv | 151 +++++++++++++++
 tb/tb_ball_track_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_track_ctrl.sv
// Frame-level sequencer for the ball detector: arms on a clean frame start, qualifies
// per-frame results (count threshold + continuity) and issues confirmed positions.
module ball_track_ctrl #(
  parameter int COLS        = 40,
  parameter int ROWS        = 30,
  parameter int MIN_COUNT   = 16,
  parameter int CONFIRM     = 2,
  parameter int LOST_FRAMES = 8,
  localparam int XW         = $clog2(COLS),
  localparam int YW         = $clog2(ROWS)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          VGA_VS,
  input  logic          DET_DONE,
  input  logic [XW-1:0] DET_X,
  input  logic [YW-1:0] DET_Y,
  input  logic [12:0]   DET_COUNT,
  output logic          DET_ENABLE,
  output logic          POS_VALID,
  input  logic          POS_READY,
  output logic [XW-1:0] POS_X,
  output logic [YW-1:0] POS_Y,
  output logic          TRACKING,
  output logic          LOST,
  output logic          OVERRUN
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, EVAL} state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [12:0]   cnt;
  } det_t;

  state_t        state;
  det_t          det_q;
  logic          vs_d, seen;
  logic [XW-1:0] last_x;
  logic [YW-1:0] last_y;
  logic [3:0]    conf_cnt;
  logic [7:0]    miss_cnt;

  logic       fs, hit, near, fs_miss, eval_hit, miss_ev, issue, accept;
  logic [6:0] ax, bx, ay, by, dx, dy;
  logic [3:0] conf_inc, conf_hit;
  logic [7:0] miss_inc;

  assign fs = vs_d & ~VGA_VS;

  always_comb begin
    ax = 7'(det_q.x);
    bx = 7'(last_x);
    ay = 7'(det_q.y);
    by = 7'(last_y);
    dx = (ax >= bx) ? ax - bx : bx - ax;
    dy = (ay >= by) ? ay - by : by - ay;
  end

  assign hit      = det_q.cnt >= 13'(MIN_COUNT);
  assign near     = (dx <= 7'd1) && (dy <= 7'd1);
  assign conf_inc = (conf_cnt >= 4'(CONFIRM)) ? 4'(CONFIRM) : conf_cnt + 4'd1;
  // a jump away from the last hit restarts confirmation from this hit
  assign conf_hit = (near || conf_cnt == 4'd0) ? conf_inc : 4'd1;
  assign miss_inc = (miss_cnt >= 8'(LOST_FRAMES)) ? 8'(LOST_FRAMES) : miss_cnt + 8'd1;

  // frame start with no result seen; a coincident DET_DONE still belongs to this frame
  assign fs_miss  = (state == RUN) && fs && !seen && !DET_DONE;
  assign eval_hit = (state == EVAL) && hit;
  assign miss_ev  = ((state == EVAL) && !hit) || fs_miss;
  assign issue    = eval_hit && (TRACKING || conf_hit == 4'(CONFIRM));
  assign accept   = POS_VALID && POS_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      det_q      <= '0;
      vs_d       <= 1'b1;
      seen       <= 1'b0;
      last_x     <= '0;
      last_y     <= '0;
      conf_cnt   <= '0;
      miss_cnt   <= '0;
      DET_ENABLE <= 1'b0;
      POS_VALID  <= 1'b0;
      POS_X      <= '0;
      POS_Y      <= '0;
      TRACKING   <= 1'b0;
      LOST       <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      vs_d <= VGA_VS;
      if (!START) begin
        state      <= IDLE;
        seen       <= 1'b0;
        conf_cnt   <= '0;
        miss_cnt   <= '0;
        DET_ENABLE <= 1'b0;
        POS_VALID  <= 1'b0;
        TRACKING   <= 1'b0;
        LOST       <= 1'b0;
        OVERRUN    <= 1'b0;
      end else begin
        DET_ENABLE <= (state == RUN) || (state == EVAL);
        case (state)
          IDLE: state <= SYNC;
          SYNC: if (fs) state <= RUN;
          RUN:  if (DET_DONE) begin
                  state <= EVAL;
                  det_q <= '{x: DET_X, y: DET_Y, cnt: DET_COUNT};
                end
          EVAL: state <= RUN;
        endcase

        if (fs)                            seen <= 1'b0;
        else if (state == RUN && DET_DONE) seen <= 1'b1;

        if (eval_hit) begin
          last_x   <= det_q.x;
          last_y   <= det_q.y;
          conf_cnt <= conf_hit;
          if (near || conf_cnt == 4'd0) miss_cnt <= '0;
          if (conf_hit == 4'(CONFIRM)) begin
            TRACKING <= 1'b1;
            LOST     <= 1'b0;
          end
        end else if (miss_ev) begin
          miss_cnt <= miss_inc;
          if (miss_inc == 8'(LOST_FRAMES) && TRACKING) begin
            TRACKING <= 1'b0;
            LOST     <= 1'b1;
            conf_cnt <= '0;
          end
        end

        // a fresh position overrides a pending acceptance on the same edge
        if (issue) begin
          POS_X     <= det_q.x;
          POS_Y     <= det_q.y;
          POS_VALID <= 1'b1;
          if (POS_VALID && !POS_READY) OVERRUN <= 1'b1;
        end else if (accept) begin
          POS_VALID <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ball_track_ctrl.sv
// Bench for ball_track_ctrl: per-frame expectations queued at DET_DONE and
// compared once the evaluation result lands.
module tb_ball_track_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N, START, VGA_VS, DET_DONE, POS_READY;
  logic [5:0] DET_X;
  logic [4:0] DET_Y;
  logic [12:0] DET_COUNT;
  logic       DET_ENABLE, POS_VALID, TRACKING, LOST, OVERRUN;
  logic [5:0] POS_X;
  logic [4:0] POS_Y;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       trk, lost, pv, ovr;
    logic [5:0] px;
    logic [4:0] py;
  } exp_t;

  exp_t sb[$];

  ball_track_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .VGA_VS(VGA_VS),
    .DET_DONE(DET_DONE), .DET_X(DET_X), .DET_Y(DET_Y), .DET_COUNT(DET_COUNT),
    .DET_ENABLE(DET_ENABLE), .POS_VALID(POS_VALID), .POS_READY(POS_READY),
    .POS_X(POS_X), .POS_Y(POS_Y), .TRACKING(TRACKING), .LOST(LOST), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic exp_t mk(input logic trk, lost, pv, input int px, py, input logic ovr);
    exp_t e;
    e.trk = trk; e.lost = lost; e.pv = pv; e.ovr = ovr;
    e.px = 6'(px); e.py = 5'(py);
    return e;
  endfunction

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_trk"},  TRACKING,  e.trk);
      chk({tag, "_lost"}, LOST,      e.lost);
      chk({tag, "_pv"},   POS_VALID, e.pv);
      chk({tag, "_px"},   POS_X,     e.px);
      chk({tag, "_py"},   POS_Y,     e.py);
      chk({tag, "_ovr"},  OVERRUN,   e.ovr);
    end
  endtask

  // DET_DONE launched here, sampled next edge, result visible the edge after
  task automatic det(input string tag, input int x, y, cnt, input exp_t e);
    sb.push_back(e);
    DET_X = 6'(x); DET_Y = 5'(y); DET_COUNT = 13'(cnt);
    DET_DONE = 1'b1;
    tick(1);
    DET_DONE = 1'b0;
    tick(1);
    sb_check(tag);
  endtask

  task automatic vsync();
    VGA_VS = 1'b0;
    tick(2);
    VGA_VS = 1'b1;
    tick(1);
  endtask

  task automatic arm();
    VGA_VS = 1'b0;
    tick(1);
    chk("arm_pre", DET_ENABLE, 0);
    tick(1);
    chk("arm_en", DET_ENABLE, 1);
    VGA_VS = 1'b1;
    tick(1);
  endtask

  task automatic consume(input string tag);
    POS_READY = 1'b1;
    tick(1);
    chk(tag, POS_VALID, 0);
    POS_READY = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; VGA_VS = 1'b1; DET_DONE = 1'b0; POS_READY = 1'b0;
    DET_X = '0; DET_Y = '0; DET_COUNT = '0;
    tick(2);
    chk("rst_en",   DET_ENABLE, 0);
    chk("rst_pv",   POS_VALID,  0);
    chk("rst_px",   POS_X,      0);
    chk("rst_py",   POS_Y,      0);
    chk("rst_trk",  TRACKING,   0);
    chk("rst_lost", LOST,       0);
    chk("rst_ovr",  OVERRUN,    0);
    RST_N = 1'b1;
    tick(1);

    // arm; a DET_DONE while waiting for frame start must be ignored
    START = 1'b1;
    tick(1);
    DET_X = 6'd9; DET_Y = 5'd5; DET_COUNT = 13'd40; DET_DONE = 1'b1;
    tick(1);
    DET_DONE = 1'b0;
    tick(2);
    chk("sync_ignore_en", DET_ENABLE, 0);
    arm();

    // confirm
    det("conf1", 10, 5, 40, mk(0, 0, 0, 0, 0, 0));
    vsync();
    det("conf2", 11, 5, 40, mk(1, 0, 1, 11, 5, 0));
    consume("conf_acc");
    vsync();

    // lost after 8 missed frames
    for (int i = 0; i < 8; i++) begin
      det($sformatf("lost%0d", i), 11, 5, 3, (i < 7) ? mk(1, 0, 0, 11, 5, 0) : mk(0, 1, 0, 11, 5, 0));
      vsync();
    end
    det("recov1", 3, 3, 40, mk(0, 1, 0, 11, 5, 0));
    vsync();
    det("recov2", 4, 4, 40, mk(1, 0, 1, 4, 4, 0));

    // stop mid-frame with a pending position
    START = 1'b0;
    tick(1);
    chk("stop_en",  DET_ENABLE, 0);
    chk("stop_pv",  POS_VALID,  0);
    chk("stop_trk", TRACKING,   0);
    chk("stop_px",  POS_X,      4);
    START = 1'b1;
    tick(1);
    arm();

    // discontinuity restarts confirmation
    det("disc1", 10, 5, 40, mk(0, 0, 0, 4, 4, 0));
    vsync();
    det("disc2", 20, 5, 40, mk(0, 0, 0, 4, 4, 0));
    vsync();
    det("disc3", 21, 6, 40, mk(1, 0, 1, 21, 6, 0));
    consume("disc_acc");
    vsync();

    // backpressure -> overrun replacement
    det("bp1", 5, 5, 40, mk(1, 0, 1, 5, 5, 0));
    vsync();
    det("bp2", 6, 5, 40, mk(1, 0, 1, 6, 5, 1));
    consume("bp_acc");
    chk("bp_px_hold", POS_X, 6);

    // two frame starts without DET_DONE count as misses: 6 more drop tracking
    vsync();
    vsync();
    vsync();
    for (int i = 0; i < 6; i++) begin
      det($sformatf("fsm%0d", i), 6, 5, 3, (i < 5) ? mk(1, 0, 0, 6, 5, 1) : mk(0, 1, 0, 6, 5, 1));
      vsync();
    end

    // asynchronous reset between edges
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_en",   DET_ENABLE, 0);
    chk("arst_lost", LOST,       0);
    chk("arst_ovr",  OVERRUN,    0);
    chk("arst_px",   POS_X,      0);
    RST_N = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
